// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V execute/memory slice.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // ALU operation select codes driven by the main/ALU decoders
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_e;

endpackage

// File: rtl/riscv_dmem.sv
// Word-organised data memory: synchronous write, gated combinational read.
// Contents survive reset; only the write strobe is blocked while rst is high.
module riscv_dmem
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] word_idx,
    input  logic                     read_en,
    input  logic                     write_en,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    // Declaration initialiser gives the zeroed power-up image (sim and FPGA)
    logic [XLEN-1:0] mem_q [DEPTH] = '{default: '0};
    logic            wr_en;

    // Write qualification and gated read mux
    always_comb begin
        wr_en = write_en & ~rst;
        rdata = read_en ? mem_q[word_idx] : '0;
    end

    // Synchronous word write; no reset on the array itself
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_exec_mem_stage.sv
// Execute/memory slice of the single-cycle core: PC register, ALU,
// data memory and write-back select.
module riscv_exec_mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     DMEM_WORDS = 256,
    parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP    = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    output logic [XLEN-1:0] pc,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] wb_data
);

    localparam int unsigned IDX_W = $clog2(DMEM_WORDS);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  rd_data;
    logic [IDX_W-1:0] word_idx;

    // Next PC: advance by PC_STEP when enabled, wraps modulo 2^32
    always_comb begin
        pc_d = pc_en ? (pc_q + PC_STEP) : pc_q;
    end

    // PC register with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // ALU: unknown op codes produce zero
    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR: alu_result = ~(op_a | op_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Byte address to word index: drop byte offset and upper bits (address wrap)
    always_comb begin
        word_idx = alu_result[IDX_W+1:2];
    end

    riscv_dmem #(
        .DEPTH (DMEM_WORDS)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .word_idx (word_idx),
        .read_en  (mem_read),
        .write_en (mem_write),
        .wdata    (store_data),
        .rdata    (rd_data)
    );

    // Write-back select: load data or ALU result
    always_comb begin
        wb_data = mem_read ? rd_data : alu_result;
    end

endmodule

// File: tb/tb_riscv_exec_mem_stage.sv
// Self-checking bench for riscv_exec_mem_stage.
module tb_riscv_exec_mem_stage;

    localparam int unsigned WORDS = 256;
    localparam int unsigned SPAN  = WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, pc_en2;
    logic [3:0]  alu_ctl;
    logic [31:0] op_a, op_b, store_data;
    logic        mem_read, mem_write;
    logic [31:0] pc, alu_result, wb_data;
    logic        alu_zero;
    logic [31:0] pc2, alu_result2, wb_data2;
    logic        alu_zero2;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] pc_ref;

    riscv_exec_mem_stage #(
        .DMEM_WORDS (WORDS),
        .PC_RESET   (32'h0000_0000),
        .PC_STEP    (32'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_en      (pc_en),
        .pc         (pc),
        .alu_ctl    (alu_ctl),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .store_data (store_data),
        .wb_data    (wb_data)
    );

    // Second instance only used for the PC wrap-around check
    riscv_exec_mem_stage #(
        .DMEM_WORDS (WORDS),
        .PC_RESET   (32'hFFFF_FFFC),
        .PC_STEP    (32'd4)
    ) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .pc_en      (pc_en2),
        .pc         (pc2),
        .alu_ctl    (alu_ctl),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result2),
        .alu_zero   (alu_zero2),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .store_data (store_data),
        .wb_data    (wb_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            0:  return a & b;
            1:  return a | b;
            2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            6:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            7:  return (sa < sb) ? 32'd1 : 32'd0;
            12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_index(input logic [31:0] addr);
        return int'((64'(addr) % SPAN) / 4);
    endfunction

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic rd, input logic wr, input logic [31:0] sd);
        alu_ctl = c; op_a = a; op_b = b; mem_read = rd; mem_write = wr; store_data = sd;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (alu_result !== 32'h0) begin miscompares++; $display("FAIL reset_alu: got %h want %h", alu_result, 32'h0); end
        vectors++; if (alu_zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b want 1", alu_zero); end
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL reset_wb: got %h want %h", wb_data, 32'h0); end
        vectors++; if (pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL reset_pc2: got %h want %h", pc2, 32'hFFFF_FFFC); end
    endtask

    task automatic test_pc();
        logic [31:0] exp_seq [3] = '{32'd4, 32'd8, 32'd12};
        @(negedge clk); rst = 1'b0; pc_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (pc !== 32'd8) begin miscompares++; $display("FAIL pc_pre_reset: got %h want %h", pc, 32'd8); end
        rst = 1'b1;
        #1;
        vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL pc_async_reset: got %h want %h", pc, 32'd0); end
        @(posedge clk); #1;
        vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL pc_reset_hold: got %h want %h", pc, 32'd0); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++; if (pc !== exp_seq[i]) begin miscompares++; $display("FAIL pc_step%0d: got %h want %h", i, pc, exp_seq[i]); end
        end
        pc_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++; if (pc !== 32'd12) begin miscompares++; $display("FAIL pc_hold%0d: got %h want %h", i, pc, 32'd12); end
        end
        pc_ref = 32'd12;
    endtask

    task automatic test_pc_wrap();
        @(negedge clk);
        vectors++; if (pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pre: got %h want %h", pc2, 32'hFFFF_FFFC); end
        pc_en2 = 1'b1;
        @(posedge clk); #1;
        pc_en2 = 1'b0;
        vectors++; if (pc2 !== 32'h0) begin miscompares++; $display("FAIL wrap_post: got %h want %h", pc2, 32'h0); end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  codes [9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd5, 4'd2, 4'd7, 4'd7};
        logic [31:0] as    [9] = '{32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] bs    [9] = '{32'h0F, 32'h0F, 32'h0F, 32'h0F, 32'h0F, 32'h0F, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] exps  [9] = '{32'h0, 32'hFF, 32'hFF, 32'hE1, 32'hFFFF_FF00, 32'h0, 32'h0, 32'd1, 32'd0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(codes[i], as[i], bs[i], 1'b0, 1'b0, 32'h0);
            #1;
            vectors++; if (alu_result !== exps[i]) begin miscompares++; $display("FAIL alu_case%0d: got %h want %h", i, alu_result, exps[i]); end
            vectors++; if (alu_zero !== (exps[i] == 32'h0)) begin miscompares++; $display("FAIL alu_zero%0d: got %b want %b", i, alu_zero, (exps[i] == 32'h0)); end
            vectors++; if (wb_data !== exps[i]) begin miscompares++; $display("FAIL alu_wb%0d: got %h want %h", i, wb_data, exps[i]); end
        end
        @(negedge clk);
        drive(4'd7, 32'h8000_0005, 32'h8000_0005, 1'b0, 1'b0, 32'h0);
        #1;
        vectors++; if (alu_result !== 32'd0) begin miscompares++; $display("FAIL slt_equal: got %h want %h", alu_result, 32'd0); end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(4'd2, 32'h100, 32'd8, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        vectors++; if (alu_result !== 32'h108) begin miscompares++; $display("FAIL st_addr: got %h want %h", alu_result, 32'h108); end
        @(posedge clk); #1;
        ref_mem[ref_index(32'h108)] = 32'hDEAD_BEEF;
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        vectors++; if (wb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ld_data: got %h want %h", wb_data, 32'hDEAD_BEEF); end
        mem_read = 1'b0;
        #1;
        vectors++; if (wb_data !== 32'h108) begin miscompares++; $display("FAIL ld_off_wb: got %h want %h", wb_data, 32'h108); end
        @(negedge clk);
        drive(4'd2, 32'h100, 32'hC, 1'b1, 1'b1, 32'h5555_AAAA);
        #1;
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL rw_old: got %h want %h", wb_data, 32'h0); end
        @(posedge clk); #1;
        ref_mem[ref_index(32'h10C)] = 32'h5555_AAAA;
        vectors++; if (wb_data !== 32'h5555_AAAA) begin miscompares++; $display("FAIL rw_new: got %h want %h", wb_data, 32'h5555_AAAA); end
        mem_write = 1'b0;
    endtask

    task automatic test_aliasing();
        @(negedge clk);
        drive(4'd2, 32'h100, 32'h0, 1'b0, 1'b1, 32'hCAFE_0100);
        @(posedge clk); #1;
        ref_mem[ref_index(32'h100)] = 32'hCAFE_0100;
        drive(4'd2, 32'h100, 32'h3, 1'b1, 1'b0, 32'h0);
        #1;
        vectors++; if (wb_data !== 32'hCAFE_0100) begin miscompares++; $display("FAIL alias_103: got %h want %h", wb_data, 32'hCAFE_0100); end
        op_a = 32'h400; op_b = 32'h100;
        #1;
        vectors++; if (wb_data !== 32'hCAFE_0100) begin miscompares++; $display("FAIL alias_500: got %h want %h", wb_data, 32'hCAFE_0100); end
        op_b = 32'h108;
        #1;
        vectors++; if (wb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL alias_508: got %h want %h", wb_data, 32'hDEAD_BEEF); end
        mem_read = 1'b0;
    endtask

    task automatic test_reset_store();
        @(negedge clk);
        rst = 1'b1;
        drive(4'd2, 32'd4, 32'd0, 1'b0, 1'b1, 32'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; pc_ref = 32'd0;
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL rst_store_dropped: got %h want %h", wb_data, 32'h0); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_store_pc: got %h want %h", pc, 32'h0); end
        op_a = 32'h100; op_b = 32'd8;
        #1;
        vectors++; if (wb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rst_retained: got %h want %h", wb_data, 32'hDEAD_BEEF); end
        mem_read = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  codes [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [3:0]  c;
        logic [31:0] a, b, sd, exp_alu, exp_wb;
        logic        rd, wr, en;
        int          idx;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                c  = 4'd2;
                a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
                b  = 32'($urandom_range(0, 3));
            end else begin
                c  = ($urandom_range(0, 6) == 6) ? 4'($urandom) : codes[$urandom_range(0, 5)];
                a  = $urandom;
                b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            end
            rd = 1'($urandom); wr = 1'($urandom); en = 1'($urandom); sd = $urandom;
            drive(c, a, b, rd, wr, sd);
            pc_en = en;
            exp_alu = ref_alu(int'(c), a, b);
            idx     = ref_index(exp_alu);
            exp_wb  = rd ? ref_mem[idx] : exp_alu;
            #1;
            vectors++; if (alu_result !== exp_alu) begin miscompares++; $display("FAIL rnd_alu%0d: op %0d a %h b %h got %h want %h", i, c, a, b, alu_result, exp_alu); end
            vectors++; if (alu_zero !== (exp_alu == 32'h0)) begin miscompares++; $display("FAIL rnd_zero%0d: got %b want %b", i, alu_zero, (exp_alu == 32'h0)); end
            vectors++; if (wb_data !== exp_wb) begin miscompares++; $display("FAIL rnd_wb%0d: got %h want %h", i, wb_data, exp_wb); end
            vectors++; if (pc !== pc_ref) begin miscompares++; $display("FAIL rnd_pc%0d: got %h want %h", i, pc, pc_ref); end
            @(posedge clk); #1;
            if (wr) ref_mem[idx] = sd;
            if (en) pc_ref = pc_ref + 32'd4;
        end
        @(negedge clk);
        drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        pc_en = 1'b0;
        #1;
        vectors++; if (pc !== pc_ref) begin miscompares++; $display("FAIL rnd_pc_final: got %h want %h", pc, pc_ref); end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
        pc_ref = 32'h0;
        rst = 1'b1; pc_en = 1'b0; pc_en2 = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_pc();
        test_pc_wrap();
        test_alu_sweep();
        test_store_load();
        test_aliasing();
        test_reset_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
